square: RTL and testbench
=========================

# square

Iterative integer squarer: accepts an `IN_W`-bit value and returns its square using one shift-add step per clock. With the residual option it returns `y*y + r`. That reconstructs the original radicand from a square-root result and remainder, so `square` is the inverse stage of the existing root datapath and serves as its in-system checker. It is a single-clock FSM block using the same level-ready handshake style as the rest of the arithmetic units.

## Interface
- `IN_W`, default 4: operand width.
- `OUT_W`, default `2*IN_W`: result width; must be `>= 2*IN_W`.
- `clk` input, 1: clock, rising edge.
- `rst_n` input, 1: reset, asynchronous and active-low.
- `y_in` input, `IN_W`: operand; sampled only at the accept edge.
- `y_ready` input, 1: operand-valid strobe; honoured only in IDLE.
- `r_in` input, `OUT_W`: residual addend; present only with `SQUARE_RESID_EN`.
- `x_out` output, `OUT_W`: result; held until the next result is written.
- `x_ready` output, 1: result-valid level.
- `x_ovf` output, 1: sum wrapped past `OUT_W`; present only with `SQUARE_RESID_EN`.

## Operation
- Internal registers:
  - `a` (`OUT_W`): multiplicand, shifted left each step.
  - `b` (`IN_W`): multiplier, shifted right each step.
  - `acc` (`OUT_W+1`): accumulator.
  - `cnt` (`$clog2(IN_W+1)`): step counter.
- States: IDLE, CALC, FIN.
- IDLE, when `y_ready`=1 (the accept edge):
  - `a` <= zero-extended `y_in`; `b` <= `y_in`; `acc` <= 0; `cnt` <= 0.
  - `x_ready` <= 0; go to CALC.
  - When `y_ready`=0, stay in IDLE and hold everything.
- CALC, every cycle:
  - If `b[0]`, then `acc` <= `acc + a`.
  - `a` <= `a << 1`; `b` <= `b >> 1`; `cnt` <= `cnt + 1`.
  - When `cnt == IN_W-1`, go to FIN.
- FIN:
  - `x_out` <= `acc[OUT_W-1:0]`.
  - `x_ready` <= 1; go to IDLE.
- Arithmetic is unsigned. Without the residual option the product always fits in `OUT_W`.
- `y_ready` is ignored in CALC and FIN. It is not queued: the producer must hold it, or re-assert it after `x_ready` rises.
- An operand of 0 still runs all `IN_W` CALC steps, so latency is fixed and data-independent.
- Unused state encodings return to IDLE.

## Timing
- Reset values: `x_out`=0, `x_ready`=0, `x_ovf`=0, state IDLE; internal registers are 0.
- Latency: the accept edge is edge 0, CALC runs on edges 1..`IN_W`, and FIN is edge `IN_W+1`. `x_ready` is high after edge `IN_W+1`, which is 5 cycles for the default width.
- `x_ready` is a level, not a pulse:
  - It stays high until the next accept edge, which clears it on that same edge.
  - `x_out` keeps the old value until FIN.
- Back-to-back operation: `y_ready` held high in IDLE right after FIN is accepted on the very next edge. Sustained throughput is one result per `IN_W+2` cycles.
- Reset asserted mid-operation aborts immediately to the reset values; the partial result is discarded.
- Reset deassertion is synchronised outside this block.

## Configuration
- `SQUARE_RESID_EN` defined:
  - Adds the `r_in` and `x_ovf` ports.
  - `r_in` is captured at the accept edge; FIN adds it to `acc`.
  - `x_out` = `(y*y + r) mod 2^OUT_W`, and `x_ovf` = carry bit `OUT_W` of that sum.
  - `x_ovf` is updated at FIN and cleared on accept, like `x_ready`.
  - Latency is unchanged.
- `SQUARE_RESID_EN` undefined: neither port exists and the datapath has no residual adder.

## Structure
- `square_pkg` holds:
  - the state enum `square_state_t` (IDLE, CALC, FIN);
  - the default-width localparams `SQUARE_IN_W`=4 and `SQUARE_OUT_W`=8.
- The root block imports the same package constants, so the two stages agree on widths.
- No sub-module: the one-bit shift-add step is three registers plus one adder and stays inline.

## Test plan
- Reset, then `y_in`=15 with `y_ready` for 1 cycle -> `x_ready` rises 5 cycles after accept, `x_out`=225.
- `y_in`=0 -> `x_out`=0 after the same 5 cycles; `y_in`=1 -> 1; `y_in`=7 -> 49.
- `y_ready` held high continuously with `y_in`=3, then 12 -> `x_out` sequence 9, 144. `x_ready` drops on each accept edge, and results are 6 cycles apart.
- `y_ready` pulsed during CALC -> ignored; the result matches the first operand, and no extra result appears.
- `rst_n` pulled low on the 2nd CALC cycle -> `x_out`=0 and `x_ready`=0 immediately. The next operand 5 gives 25.
- `SQUARE_RESID_EN` cases:
  - `y`=11, `r`=7 -> `x_out`=128, `x_ovf`=0.
  - `y`=15, `r`=40 -> `x_out`=9, `x_ovf`=1.
  - Sweep `x` over 0..255 through the root block, then this block with its remainder -> `x_out`=`x` for all 256 values.

Source files
------------

// File: rtl/square_pkg.sv
// square_pkg: state type and default widths shared by the squarer and the root datapath.
package square_pkg;
    typedef enum logic [1:0] {IDLE, CALC, FIN} square_state_t;
    localparam int SQUARE_IN_W = 4;
    localparam int SQUARE_OUT_W = 8;
endpackage

// File: rtl/square.sv
// square: iterative shift-add squarer, one multiplier bit per clock, level-ready handshake.
// SQUARE_RESID_EN adds r_in (added at FIN, giving y*y + r) and the carry-out flag x_ovf.
module square
    import square_pkg::*;
#(
    parameter int IN_W  = SQUARE_IN_W,
    parameter int OUT_W = 2 * IN_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [IN_W-1:0]  y_in,
    input  logic             y_ready,
`ifdef SQUARE_RESID_EN
    input  logic [OUT_W-1:0] r_in,
    output logic             x_ovf,
`endif
    output logic [OUT_W-1:0] x_out,
    output logic             x_ready
);
    localparam int CW = $clog2(IN_W + 1);
    localparam logic [CW-1:0] LAST = CW'(IN_W - 1);

    square_state_t    r_state;
    logic [OUT_W-1:0] r_a;
    logic [IN_W-1:0]  r_b;
    logic [OUT_W:0]   r_acc;
    logic [CW-1:0]    r_cnt;
`ifdef SQUARE_RESID_EN
    logic [OUT_W-1:0] r_resid;
    logic [OUT_W:0]   w_sum;
    assign w_sum = r_acc + {1'b0, r_resid};
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_acc   <= '0;
            r_cnt   <= '0;
            x_out   <= '0;
            x_ready <= 1'b0;
`ifdef SQUARE_RESID_EN
            r_resid <= '0;
            x_ovf   <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: if (y_ready) begin
                    r_a     <= OUT_W'(y_in);
                    r_b     <= y_in;
                    r_acc   <= '0;
                    r_cnt   <= '0;
                    x_ready <= 1'b0;
`ifdef SQUARE_RESID_EN
                    r_resid <= r_in;
                    x_ovf   <= 1'b0;
`endif
                    r_state <= CALC;
                end
                CALC: begin
                    if (r_b[0]) r_acc <= r_acc + {1'b0, r_a};
                    r_a     <= r_a << 1;
                    r_b     <= r_b >> 1;
                    r_cnt   <= r_cnt + 1'b1;
                    r_state <= (r_cnt == LAST) ? FIN : CALC;
                end
                FIN: begin
`ifdef SQUARE_RESID_EN
                    x_out   <= w_sum[OUT_W-1:0];
                    x_ovf   <= w_sum[OUT_W];
`else
                    x_out   <= r_acc[OUT_W-1:0];
`endif
                    x_ready <= 1'b1;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_square.sv
// tb_square: scoreboard bench for square; expected squares are queued at accept, checked at x_ready.
module tb_square;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] y_in = '0;
    logic       y_ready = 1'b0;
    logic [7:0] r_in = '0;
    logic [7:0] x_out;
    logic       x_ready;
    logic       ovf;
    logic [8:0] exp_q[$];
    logic [8:0] e;
    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    square dut (
        .clk(clk), .rst_n(rst_n), .y_in(y_in), .y_ready(y_ready),
`ifdef SQUARE_RESID_EN
        .r_in(r_in), .x_ovf(ovf),
`endif
        .x_out(x_out), .x_ready(x_ready)
    );
`ifndef SQUARE_RESID_EN
    assign ovf = 1'b0;
`endif

    task automatic start(input int y, input int r);
        @(negedge clk);
        y_in = 4'(y);
        r_in = 8'(r);
        y_ready = 1'b1;
`ifdef SQUARE_RESID_EN
        exp_q.push_back(9'(y * y + r));
`else
        exp_q.push_back(9'(y * y));
`endif
        @(posedge clk);
        #1 y_ready = 1'b0;
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        while (!x_ready && n < 20) begin
            @(posedge clk);
            #1 n++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        checks++;
        if (x_out !== 8'd0 || x_ready !== 1'b0 || ovf !== 1'b0) begin
            errors++;
            $display("FAIL reset: x_out=%0d x_ready=%b ovf=%b, want 0 0 0", x_out, x_ready, ovf);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        int ys[4] = '{15, 0, 1, 7};
        int n;
        foreach (ys[i]) begin
            start(ys[i], 0);
            checks++;
            if (x_ready !== 1'b0) begin
                errors++;
                $display("FAIL accept_clear y=%0d: x_ready=%b want 0", ys[i], x_ready);
            end
            wait_ready(n);
            e = exp_q.pop_front();
            checks++;
            if (n != 5 || x_out !== e[7:0]) begin
                errors++;
                $display("FAIL square y=%0d: x_out=%0d after %0d cycles, want %0d after 5", ys[i], x_out, n, e[7:0]);
            end
        end
        repeat (3) @(posedge clk);
        #1 checks++;
        if (x_ready !== 1'b1 || x_out !== 8'd49) begin
            errors++;
            $display("FAIL hold: x_ready=%b x_out=%0d, want 1 49", x_ready, x_out);
        end
    endtask

    task automatic test_back_to_back();
        int c = 0;
        int first = -1;
        logic prev = x_ready;
        @(negedge clk);
        y_in = 4'd3;
        y_ready = 1'b1;
        exp_q.push_back(9'd9);
        @(posedge clk);
        #1 y_in = 4'd12;
        exp_q.push_back(9'd144);
        checks++;
        if (x_ready !== 1'b0) begin
            errors++;
            $display("FAIL b2b_clear0: x_ready=%b want 0", x_ready);
        end
        prev = x_ready;
        while (c < 30 && exp_q.size() != 0) begin
            @(posedge clk);
            #1 c++;
            if (x_ready && !prev) begin
                e = exp_q.pop_front();
                checks++;
                if (x_out !== e[7:0]) begin
                    errors++;
                    $display("FAIL b2b_value: x_out=%0d want %0d", x_out, e[7:0]);
                end
                if (first < 0) first = c;
                else begin
                    y_ready = 1'b0;
                    checks++;
                    if (c - first != 6) begin
                        errors++;
                        $display("FAIL b2b_spacing: %0d cycles want 6", c - first);
                    end
                end
            end
            if (first >= 0 && c == first + 1) begin
                checks++;
                if (x_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL b2b_clear1: x_ready=%b want 0", x_ready);
                end
            end
            prev = x_ready;
        end
        y_ready = 1'b0;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL b2b_timeout: %0d results missing, want 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_ignore();
        int n;
        start(6, 0);
        @(posedge clk);
        #1 y_in = 4'd9;
        y_ready = 1'b1;
        @(posedge clk);
        #1 y_ready = 1'b0;
        wait_ready(n);
        e = exp_q.pop_front();
        checks++;
        if (!x_ready || x_out !== e[7:0]) begin
            errors++;
            $display("FAIL ignore: x_ready=%b x_out=%0d, want 1 %0d", x_ready, x_out, e[7:0]);
        end
        repeat (10) @(posedge clk);
        #1 checks++;
        if (x_ready !== 1'b1 || x_out !== 8'd36) begin
            errors++;
            $display("FAIL no_extra: x_ready=%b x_out=%0d, want 1 36", x_ready, x_out);
        end
    endtask

    task automatic test_reset_mid();
        int n;
        start(10, 0);
        void'(exp_q.pop_back());
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1 checks++;
        if (x_out !== 8'd0 || x_ready !== 1'b0) begin
            errors++;
            $display("FAIL abort: x_out=%0d x_ready=%b, want 0 0", x_out, x_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        start(5, 0);
        wait_ready(n);
        e = exp_q.pop_front();
        checks++;
        if (n != 5 || x_out !== e[7:0]) begin
            errors++;
            $display("FAIL after_abort: x_out=%0d after %0d, want %0d after 5", x_out, n, e[7:0]);
        end
    endtask

`ifdef SQUARE_RESID_EN
    task automatic test_resid();
        int n;
        int ys[2] = '{11, 15};
        int rs[2] = '{7, 40};
        foreach (ys[i]) begin
            start(ys[i], rs[i]);
            wait_ready(n);
            e = exp_q.pop_front();
            checks++;
            if (n != 5 || x_out !== e[7:0] || ovf !== e[8]) begin
                errors++;
                $display("FAIL resid y=%0d r=%0d: x_out=%0d ovf=%b, want %0d %b", ys[i], rs[i], x_out, ovf, e[7:0], e[8]);
            end
        end
    endtask

    task automatic test_sweep();
        int n, y, bad;
        bad = 0;
        for (int x = 0; x < 256; x++) begin
            y = 0;
            while ((y + 1) * (y + 1) <= x) y++;
            start(y, x - y * y);
            wait_ready(n);
            e = exp_q.pop_front();
            if (x_out !== 8'(x) || ovf !== 1'b0) begin
                bad++;
                if (bad < 5) $display("FAIL sweep x=%0d: x_out=%0d ovf=%b", x, x_out, ovf);
            end
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL sweep: %0d bad values, want 0", bad);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_ignore();
        test_reset_mid();
`ifdef SQUARE_RESID_EN
        test_resid();
        test_sweep();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
